// File: rtl/weight_bank_loader.sv
// Packs a valid/ready byte stream into four weight banks (3 x N_FULL bytes, then N_LAST bytes), byte 0 at the LSBs.
// Latency: LOAD is entered one cycle after start and done follows the final transfer edge. in_valid=0 stalls indefinitely.
module weight_bank_loader #(
  parameter int BYTE_W = 8,
  parameter int N_FULL = 62,
  parameter int N_LAST = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_FULL*BYTE_W-1:0] w0,
  output logic [N_FULL*BYTE_W-1:0] w1,
  output logic [N_FULL*BYTE_W-1:0] w2,
  output logic [N_LAST*BYTE_W-1:0] w3,
  output logic [1:0]               bank_idx,
  output logic [5:0]               byte_idx,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] bank_q, bank_d;
  logic [5:0] byte_q, byte_d;
  logic [N_FULL*BYTE_W-1:0] w0_q, w1_q, w2_q;
  logic [N_LAST*BYTE_W-1:0] w3_q;
  logic xfer;

  assign xfer = in_valid && (state_q == S_LOAD);

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          bank_d  = 2'd0;
          byte_d  = 6'd0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (bank_q == 2'd3) begin
            // Counters park on the final position once the load completes.
            if (byte_q == 6'(N_LAST - 1)) state_d = S_DONE;
            else                          byte_d  = byte_q + 6'd1;
          end else if (byte_q == 6'(N_FULL - 1)) begin
            byte_d = 6'd0;
            bank_d = bank_q + 2'd1;
          end else begin
            byte_d = byte_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bank_q  <= 2'd0;
      byte_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      byte_q  <= byte_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0_q <= '0;
      w1_q <= '0;
      w2_q <= '0;
      w3_q <= '0;
    end else if (xfer) begin
      for (int i = 0; i < N_FULL; i++) begin
        if (byte_q == 6'(i)) begin
          if (bank_q == 2'd0) w0_q[i*BYTE_W +: BYTE_W] <= in_data;
          if (bank_q == 2'd1) w1_q[i*BYTE_W +: BYTE_W] <= in_data;
          if (bank_q == 2'd2) w2_q[i*BYTE_W +: BYTE_W] <= in_data;
        end
      end
      for (int j = 0; j < N_LAST; j++) begin
        if (bank_q == 2'd3 && byte_q == 6'(j)) w3_q[j*BYTE_W +: BYTE_W] <= in_data;
      end
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign bank_idx = bank_q;
  assign byte_idx = byte_q;
  assign w0       = w0_q;
  assign w1       = w1_q;
  assign w2       = w2_q;
  assign w3       = w3_q;

endmodule

// File: tb/tb_weight_bank_loader.sv
// Randomized bench for weight_bank_loader: a flat 216-byte reference image is checked at every rising done.
module tb_weight_bank_loader;
  localparam int NB = 216;
  localparam int VW = NB * 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic in_ready;
  logic [495:0] w0, w1, w2;
  logic [239:0] w3;
  logic [1:0] bank_idx;
  logic [5:0] byte_idx;
  logic busy, done;

  weight_bank_loader #(.BYTE_W(8), .N_FULL(62), .N_LAST(30)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .bank_idx(bank_idx), .byte_idx(byte_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [7:0] mem [NB];
  logic [VW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] model_image();
    logic [VW-1:0] img;
    img = '0;
    for (int k = 0; k < NB; k++) img[k*8 +: 8] = mem[k];
    return img;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_img(input string nm, input logic [VW-1:0] exp);
    logic [VW-1:0] act;
    int first;
    act = {w3, w2, w1, w0};
    n_checks++;
    if (act == exp) n_pass++;
    else begin
      first = -1;
      for (int k = NB - 1; k >= 0; k--) if (act[k*8 +: 8] != exp[k*8 +: 8]) first = k;
      $display("FAIL %s: byte %0d got %02h expected %02h (t=%0t)", nm, first,
               act[first*8 +: 8], exp[first*8 +: 8], $time);
    end
  endtask

  // Monitor: every rising done must match the oldest outstanding image.
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: done rose with no load outstanding (t=%0t)", $time);
        end else begin
          check_img("bank_image_at_done", exp_q.pop_front());
        end
      end
      prev_done = done;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit rdy, ok;
    if (stall) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL xfer_timeout: in_ready never seen within 64 cycles (t=%0t)", $time);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // kind 0: k mod 256, 1: constant c, 2: random. start_at pulses start alongside that byte.
  task automatic load(input int kind, input logic [7:0] c, input bit stall, input int n, input int start_at);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = (kind == 0) ? 8'(k) : (kind == 1) ? c : 8'($urandom);
      mem[k] = b;
      if (k == NB - 1) begin
        exp_q.push_back(model_image());
        check("done_low_before_last", done, 0);
      end
      if (k == start_at) start = 1'b1;
      send_byte(b, stall);
      start = 1'b0;
      if (k == 60) begin
        check("bank_before_wrap", bank_idx, 0);
        check("byte_before_wrap", byte_idx, 61);
      end
      if (k == 61) begin
        check("bank_after_wrap", bank_idx, 1);
        check("byte_after_wrap", byte_idx, 0);
      end
    end
  endtask

  initial begin
    int s;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int k = 0; k < NB; k++) mem[k] = 8'd0;

    // Reset values
    #1 rst = 1'b1;
    #20;
    check("rst_banks_zero", ({w3, w2, w1, w0} == '0), 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bank_idx", bank_idx, 0);
    check("rst_byte_idx", byte_idx, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 0);

    // Full back-to-back load, latency and spot bytes
    s = cyc;
    do_start();
    check("load_busy", busy, 1);
    check("load_in_ready", in_ready, 1);
    load(0, 8'h00, 1'b0, NB, -1);
    check("b2b_done", done, 1);
    check("b2b_latency", cyc - s, 217);
    check("done_busy", busy, 0);
    check("done_in_ready", in_ready, 0);
    check("w0_first", w0[7:0], 8'h00);
    check("w0_last", w0[495:488], 8'h3D);
    check("w1_first", w1[7:0], 8'h3E);
    check("w2_last", w2[495:488], 8'hB9);
    check("w3_first", w3[7:0], 8'hBA);
    check("w3_last", w3[239:232], 8'hD7);

    // Random stalls, random data, start ignored mid-load, bytes ignored in DONE
    do_start();
    check("restart_done_cleared", done, 0);
    load(2, 8'h00, 1'b1, NB, 100);
    repeat (6) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      check("done_state_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("done_held", done, 1);
    check_img("banks_hold_in_done", model_image());

    // Reset mid-load
    do_start();
    load(2, 8'h00, 1'b1, 70, -1);
    rst = 1'b1;
    #1;
    check("midrst_w0", (w0 == '0), 1);
    check("midrst_w1", (w1 == '0), 1);
    check("midrst_bank_idx", bank_idx, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    for (int k = 0; k < NB; k++) mem[k] = 8'd0;
    check_img("midrst_image", model_image());
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_start();
    load(1, 8'hA5, 1'b1, NB, -1);
    check("a5_done", done, 1);

    // Reload with 0x5A
    do_start();
    check("reload_done_drop", done, 0);
    check("reload_busy", busy, 1);
    load(1, 8'h5A, 1'b0, NB, -1);
    check("reload_done_rise", done, 1);
    check("reload_w0_5a", (w0 == {62{8'h5A}}), 1);
    check("reload_w3_5a", (w3 == {30{8'h5A}}), 1);

    repeat (3) begin @(posedge clk); #1; end
    check("no_pending_images", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/weight_bank_loader.md
Name: weight_bank_loader

Overview:
- Byte-serial writer that fills the four FNN weight banks consumed by the weight-select mux: banks 0-2 are 62 bytes (496 bits) each, bank 3 is 30 bytes (240 bits).
- Accepts a valid/ready byte stream, packs bytes into bank registers in order (bank 0 first), and flags completion.
- Sits between the external weight source (host/ROM streamer) and the mux's a0..a3 inputs.

Parameters:
- BYTE_W, 8, width of one stream word / weight.
- N_FULL, 62, bytes in banks 0, 1 and 2.
- N_LAST, 30, bytes in bank 3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a full load.
- in_data  input  BYTE_W  weight byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- w0  output  N_FULL*BYTE_W  bank 0 contents (mux a0).
- w1  output  N_FULL*BYTE_W  bank 1 contents (mux a1).
- w2  output  N_FULL*BYTE_W  bank 2 contents (mux a2).
- w3  output  N_LAST*BYTE_W  bank 3 contents (mux a3).
- bank_idx  output  2  bank currently being written.
- byte_idx  output  6  byte position within the current bank.
- busy  output  1  load in progress.
- done  output  1  all 216 bytes loaded; level, held until next start or reset.

Behaviour:
- Reset (async, rst=1): state IDLE; w0..w3 = 0; bank_idx = 0; byte_idx = 0; busy = 0; done = 0; in_ready = 0.
- States: IDLE, LOAD, DONE.
- IDLE: start=1 -> LOAD next cycle; bank_idx = 0, byte_idx = 0, busy = 1, done = 0.
- LOAD: in_ready = 1 (combinational from state). A transfer occurs on a cycle with in_valid & in_ready.
  - On a transfer, in_data is written to bits [BYTE_W*byte_idx + BYTE_W-1 : BYTE_W*byte_idx] of bank bank_idx, with byte 0 at the LSBs. The register updates at that clock edge; there are no other side effects.
  - Counter advance: byte_idx increments. In banks 0-2, on byte_idx == N_FULL-1, byte_idx wraps to 0 and bank_idx increments.
  - In bank 3, on byte_idx == N_LAST-1 the load completes: state -> DONE, busy = 0, done = 1, and in_ready drops the following cycle.
  - in_valid = 0 stalls the load; all state is held with no timeout.
  - start during LOAD is ignored and does not restart the load.
- DONE: in_ready = 0 and in_data is ignored. Banks hold their contents. start=1 -> LOAD with counters cleared and done cleared the next cycle.
- Banks are not cleared on start. Each byte is overwritten in place, so after a complete load every bit is fresh.
- Total transfers per load = 3*N_FULL + N_LAST = 216. Minimum latency from start to done is 217 cycles (1 cycle to enter LOAD plus 216 back-to-back transfers).
- Reset asserted mid-load: immediate return to the reset values above. A partial load is discarded.
- w0..w3 are direct register outputs with no combinational path from in_data.
- byte_idx width of 6 covers 0..61. Any N_FULL above 64 requires widening byte_idx.

Test Plan:
- Reset values: assert rst with outputs in arbitrary states -> all banks 0, in_ready=0, busy=0, done=0, bank_idx=0, byte_idx=0.
- Full back-to-back load: pulse start, then drive in_valid=1 with byte k = k mod 256 for k=0..215 -> done=1 exactly 217 cycles after start.
  - w0[7:0]=0x00, w0[495:488]=0x3D, w1[7:0]=0x3E, w2[495:488]=0xB9, w3[7:0]=0xBA, w3[239:232]=0xD7.
- Stalls and bank boundary: toggle in_valid randomly (about 50%) during the same stream -> identical bank contents.
  - bank_idx goes 0->1 on the edge after byte 61 transfers, and byte_idx returns to 0.
- Ignored inputs: pulse start at transfer 100, then drive extra bytes (0xFF) in DONE -> load continues unaffected, and bank contents are unchanged after done.
- Reset mid-load: assert rst after 70 transfers -> w0=0, w1=0, bank_idx=0, done=0. A new start followed by 216 bytes of 0xA5 -> all banks 0xA5 repeated.
- Reload: after a complete load, pulse start and stream 216 bytes of 0x5A -> done drops the next cycle, rises again 216 transfers later, and every byte of w0..w3 = 0x5A.
